button_conditioner: RTL and testbench

Conditions the five raw Basys push-buttons (C, L, U, R, D) before they reach the game/cursor logic in the `basys` top level. Each button goes through a 2-flop synchronizer, a stability-counter debouncer, and a press-edge detector with optional auto-repeat. The downstream stage sees clean levels and single-cycle press pulses only, and never sees a raw button.

---
 rtl/btn_pkg.sv | 13 +
 rtl/button_channel.sv | 83 ++++++++
 rtl/button_conditioner.sv | 30 +++
 tb/tb_button_conditioner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: button indices, channel state encoding and a width helper
package btn_pkg;
  localparam int BTN_D = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_L = 3;
  localparam int BTN_C = 4;
  localparam int NUM_BTN = 5;
  typedef enum logic [1:0] {IDLE, RISE_WAIT, HELD, FALL_WAIT} btn_state_t;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/button_channel.sv
// button_channel: synchronizer, debounce FSM and auto-repeat for one button
module button_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  logic sync1, sync2, rep, rep_n, level_n, press_n, rel_n;
  logic rising, waiting, start, cont, done, fire;
  btn_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [RW-1:0] rcnt, rcnt_n, rtgt;
  always_comb begin
    rising = (state == IDLE) || (state == RISE_WAIT);
    waiting = (state == RISE_WAIT) || (state == FALL_WAIT);
    start = !waiting && (sync2 == (state == IDLE));
    cont = waiting && (sync2 == (state == RISE_WAIT));
    cnt_inc = (cnt == CW'(DEBOUNCE_CYCLES)) ? cnt : cnt + 1'b1;
    done = (start && DEBOUNCE_CYCLES == 1) || (cont && cnt_inc == CW'(DEBOUNCE_CYCLES));
    rtgt = rep ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
    fire = (REPEAT_DELAY > 0) && (RW'(rcnt + 1'b1) == rtgt);
    state_n = state;
    cnt_n = cnt;
    rcnt_n = rcnt;
    rep_n = rep;
    level_n = level;
    press_n = 1'b0;
    rel_n = 1'b0;
    if (done) begin
      state_n = rising ? HELD : IDLE;
      cnt_n = '0;
      level_n = rising;
      press_n = rising;
      rel_n = !rising;
      rcnt_n = '0;
      rep_n = 1'b0;
    end else if (start) begin
      state_n = rising ? RISE_WAIT : FALL_WAIT;
      cnt_n = CW'(1);
    end else if (cont) begin
      cnt_n = cnt_inc;
    end else if (waiting) begin
      // mismatch mid-wait: fall back; rcnt untouched so repeat resumes in phase
      state_n = rising ? IDLE : HELD;
      cnt_n = '0;
    end else if (state == HELD && REPEAT_DELAY > 0) begin
      rcnt_n = fire ? '0 : rcnt + 1'b1;
      rep_n = rep | fire;
      press_n = fire;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {sync2, sync1} <= 2'b00;
      state <= IDLE;
      cnt <= '0;
      rcnt <= '0;
      rep <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
    end else begin
      {sync2, sync1} <= {sync1, raw};
      state <= state_n;
      cnt <= cnt_n;
      rcnt <= rcnt_n;
      rep <= rep_n;
      level <= level_n;
      press <= press_n;
      rel <= rel_n;
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: five independent debounced button channels {C,L,U,R,D}
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);
  for (genvar i = 0; i < NUM_BTN; i++) begin : ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .raw(btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel(btn_release[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard of expected press/release pulses per cycle
module tb_button_conditioner;
  import btn_pkg::*;
  typedef struct {
    int cyc;
    logic [4:0] p;
    logic [4:0] r;
  } ev_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] raw = '0, lvl, prs, rls;
  logic [4:0] rraw = '0, rlvl, rprs, rrls;
  int cyc = 0, checks = 0, errors = 0;
  ev_t q[$], qr[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  button_conditioner dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw),
    .btn_level(lvl), .btn_press(prs), .btn_release(rls)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut_r (
    .clk(clk), .rst_n(rst_n), .btn_raw(rraw),
    .btn_level(rlvl), .btn_press(rprs), .btn_release(rrls)
  );
  always @(negedge clk) begin
    if ((prs | rls) != 5'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b", cyc, prs, rls);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cyc !== cyc || e.p !== prs || e.r !== rls) begin
          errors++;
          $display("FAIL pulse got cyc=%0d press=%b release=%b expected cyc=%0d press=%b release=%b",
                   cyc, prs, rls, e.cyc, e.p, e.r);
        end
      end
    end
    if ((rprs | rrls) != 5'b0) begin
      checks++;
      if (qr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_repeat_pulse cyc=%0d press=%b release=%b", cyc, rprs, rrls);
      end else begin
        ev_t e;
        e = qr.pop_front();
        if (e.cyc !== cyc || e.p !== rprs || e.r !== rrls || (rprs != 5'b0 && rlvl !== rprs)) begin
          errors++;
          $display("FAIL repeat_pulse got cyc=%0d press=%b release=%b level=%b expected cyc=%0d press=%b release=%b",
                   cyc, rprs, rrls, rlvl, e.cyc, e.p, e.r);
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int c, input logic [4:0] p, input logic [4:0] r);
    ev_t e;
    e.cyc = c;
    e.p = p;
    e.r = r;
    q.push_back(e);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({lvl, prs, rls} !== 15'b0) begin
      errors++;
      $display("FAIL reset got level=%b press=%b release=%b expected all 0", lvl, prs, rls);
    end
    checks++;
    if ({rlvl, rprs, rrls} !== 15'b0) begin
      errors++;
      $display("FAIL reset_r got level=%b press=%b release=%b expected all 0", rlvl, rprs, rrls);
    end
    rst_n = 1'b1;
    tick(2);
  endtask
  task automatic test_clean_press;
    raw[BTN_D] = 1'b1;
    push(cyc + 10, 5'b00001, 5'b0);
    tick(20);
    checks++;
    if (lvl !== 5'b00001) begin
      errors++;
      $display("FAIL clean_level got %b expected 00001", lvl);
    end
    tick(20);
    raw[BTN_D] = 1'b0;
    push(cyc + 10, 5'b0, 5'b00001);
    tick(15);
    checks++;
    if (lvl !== 5'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL clean_release got level=%b pending=%0d expected 00000 pending=0", lvl, q.size());
    end
    q.delete();
  endtask
  task automatic test_glitch;
    for (int n = 0; n < 5; n++) begin
      raw[BTN_U] = 1'b1;
      tick(7);
      raw[BTN_U] = 1'b0;
      tick(3);
    end
    tick(10);
    checks++;
    if (lvl !== 5'b0) begin
      errors++;
      $display("FAIL glitch_level got %b expected 00000", lvl);
    end
    raw[BTN_U] = 1'b1;
    push(cyc + 10, 5'b00100, 5'b0);
    push(cyc + 18, 5'b0, 5'b00100);
    tick(8);
    raw[BTN_U] = 1'b0;
    tick(20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL glitch_pending got %0d expected 0", q.size());
    end
    q.delete();
  endtask
  task automatic test_bounce_release;
    int c0;
    raw[BTN_U] = 1'b1;
    push(cyc + 10, 5'b00100, 5'b0);
    tick(40);
    c0 = cyc;
    for (int j = 0; j < 6; j++) begin
      raw[BTN_U] = (j % 2 == 1);
      tick(1);
    end
    raw[BTN_U] = 1'b0;
    push(c0 + 16, 5'b0, 5'b00100);
    tick(20);
    checks++;
    if (lvl !== 5'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL bounce got level=%b pending=%0d expected 00000 pending=0", lvl, q.size());
    end
    q.delete();
  endtask
  task automatic test_repeat;
    int t;
    ev_t e;
    t = cyc + 10;
    rraw[BTN_R] = 1'b1;
    foreach (e.p[k]) e.p[k] = 1'b0;
    e.r = 5'b0;
    e.p[BTN_R] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e.cyc = t + ((k == 0) ? 0 : 15 + 5 * k);
      qr.push_back(e);
    end
    tick(50);
    rraw[BTN_R] = 1'b0;
    e.cyc = cyc + 10;
    e.r = e.p;
    e.p = 5'b0;
    qr.push_back(e);
    tick(30);
    checks++;
    if (rlvl !== 5'b0 || qr.size() != 0) begin
      errors++;
      $display("FAIL repeat_end got level=%b pending=%0d expected 00000 pending=0", rlvl, qr.size());
    end
    qr.delete();
  endtask
  task automatic test_simultaneous;
    raw[BTN_L] = 1'b1;
    raw[BTN_R] = 1'b1;
    push(cyc + 10, 5'b01010, 5'b0);
    tick(20);
    checks++;
    if (lvl !== 5'b01010) begin
      errors++;
      $display("FAIL simul_level got %b expected 01010", lvl);
    end
    raw[BTN_L] = 1'b0;
    raw[BTN_R] = 1'b0;
    push(cyc + 10, 5'b0, 5'b01010);
    tick(20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL simul_pending got %0d expected 0", q.size());
    end
    q.delete();
  endtask
  task automatic test_reset_mid_hold;
    raw[BTN_C] = 1'b1;
    push(cyc + 10, 5'b10000, 5'b0);
    tick(20);
    checks++;
    if (lvl !== 5'b10000) begin
      errors++;
      $display("FAIL hold_level got %b expected 10000", lvl);
    end
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({lvl, prs, rls} !== 15'b0) begin
      errors++;
      $display("FAIL mid_reset got level=%b press=%b release=%b expected all 0", lvl, prs, rls);
    end
    tick(1);
    rst_n = 1'b1;
    push(cyc + 10, 5'b10000, 5'b0);
    tick(20);
    checks++;
    if (lvl !== 5'b10000) begin
      errors++;
      $display("FAIL repress_level got %b expected 10000", lvl);
    end
    raw[BTN_C] = 1'b0;
    push(cyc + 10, 5'b0, 5'b10000);
    tick(20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL reset_pending got %0d expected 0", q.size());
    end
    q.delete();
  endtask
  initial begin
    test_reset;
    test_clean_press;
    test_glitch;
    test_bounce_release;
    test_repeat;
    test_simultaneous;
    test_reset_mid_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
